// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM encoding, default widths, response record.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;

  typedef struct packed {
    logic [DefDataW-1:0] rdata;
    logic                err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS wait-state counter; expired_o flags the cycle whose increment reaches the limit.
module apb_timeout_counter #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && ((cnt_q + CNT_W'(1)) == limit_i);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready to APB requester for two slaves.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned SEL_BIT        = 5,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              _PCLK,
  input  logic              _PRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              _PSEL1,
  output logic              _PSEL2,
  output logic              _PENABLE,
  output logic              _PWRITE,
  output logic [ADDR_W-1:0] _PADDR,
  output logic [DATA_W-1:0] _PWDATA,
  input  logic [DATA_W-1:0] _PRDATA,
  input  logic              _PREADY,
  input  logic              _PSLVERR
);

  localparam logic [1:0] StIdle   = IDLE;
  localparam logic [1:0] StSetup  = SETUP;
  localparam logic [1:0] StAccess = ACCESS;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              rsp_valid_q, rsp_valid_d;
  apb_rsp_t          rsp_q, rsp_d;
  logic              tmo_expired;
  logic              dec_err;

  // Any address bit above the slave-select bit set means no slave exists there.
  assign dec_err = |req_addr[ADDR_W-1:SEL_BIT+1];

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  apb_timeout_counter #(
    .CNT_W (CntW)
  ) u_timeout (
    .clk_i     (_PCLK),
    .rst_i     (_PRESET),
    .en_i      ((state_q == StAccess) && !_PREADY),
    .clr_i     (state_q == StSetup),
    .limit_i   (CntW'(TIMEOUT_CYCLES)),
    .expired_o (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rsp_valid_d = 1'b0;
    rsp_d       = rsp_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          if (dec_err) begin
            rsp_valid_d = 1'b1;
            rsp_d.err   = 1'b1;
            rsp_d.rdata = '0;
          end else begin
            state_d = StSetup;
          end
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        // _PREADY takes priority over a timeout expiring in the same cycle.
        if (_PREADY) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_d.err   = _PSLVERR;
          rsp_d.rdata = (!write_q && !_PSLVERR) ? DefDataW'(_PRDATA) : '0;
        end else if (tmo_expired) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_d.err   = 1'b1;
          rsp_d.rdata = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge _PCLK or posedge _PRESET) begin
    if (_PRESET) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  logic xfer_active;
  assign xfer_active = (state_q == StSetup) || (state_q == StAccess);

  assign _PSEL1    = xfer_active && !addr_q[SEL_BIT];
  assign _PSEL2    = xfer_active && addr_q[SEL_BIT];
  assign _PENABLE  = (state_q == StAccess);
  assign _PWRITE   = write_q;
  assign _PADDR    = addr_q;
  assign _PWDATA   = wdata_q;
  assign req_ready = (state_q == StIdle) && !rsp_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_q.err;
  assign rsp_rdata = DATA_W'(rsp_q.rdata);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed + randomized bench for apb_master_bridge with a behavioural APB memory model.
// Timeout checks are compiled in when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

  localparam int unsigned TmoCycles = 16;

  logic        _PCLK = 1'b0;
  logic        _PRESET;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        _PSEL1, _PSEL2, _PENABLE, _PWRITE;
  logic [31:0] _PADDR, _PWDATA, _PRDATA;
  logic        _PREADY, _PSLVERR;

  int total = 0;
  int bad   = 0;

  // Reference memory: word contents per address; unwritten locations read as zero.
  logic [31:0] mem [logic [31:0]];

  apb_master_bridge #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .SEL_BIT        (5),
    .TIMEOUT_CYCLES (TmoCycles)
  ) dut (
    ._PCLK     (_PCLK),
    ._PRESET   (_PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    ._PSEL1    (_PSEL1),
    ._PSEL2    (_PSEL2),
    ._PENABLE  (_PENABLE),
    ._PWRITE   (_PWRITE),
    ._PADDR    (_PADDR),
    ._PWDATA   (_PWDATA),
    ._PRDATA   (_PRDATA),
    ._PREADY   (_PREADY),
    ._PSLVERR  (_PSLVERR)
  );

  always #5 _PCLK = ~_PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // One command end to end; cycle 0 is the handshake cycle, sampling at negedges.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input int waits, input logic serr);
    int          lat;
    int          guard;
    logic [31:0] exp_rd;
    logic [31:0] exp_sel;
    guard = 0;
    while (!req_ready && guard < 8) begin
      @(negedge _PCLK);
      guard++;
    end
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(negedge _PCLK);
    req_valid = 1'b0;
    lat = 1;
    if (addr[31:6] != 26'd0) begin
      chk("dec_no_sel", {30'd0, _PSEL2, _PSEL1}, 32'd0);
      chk("dec_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("dec_rsp_err", {31'd0, rsp_err}, 32'd1);
      chk("dec_rsp_rdata", rsp_rdata, 32'd0);
    end else begin
      exp_sel = addr[5] ? 32'd2 : 32'd1;
      exp_rd  = (!wr && !serr) ? model_rd(addr) : 32'd0;
      if (wr && !serr) mem[addr] = wd;
      chk("setup_sel", {30'd0, _PSEL2, _PSEL1}, exp_sel);
      chk("setup_penable", {31'd0, _PENABLE}, 32'd0);
      chk("setup_paddr", _PADDR, addr);
      chk("setup_pwrite", {31'd0, _PWRITE}, {31'd0, wr});
      chk("setup_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      _PREADY = 1'($urandom_range(0, 1));  // must be ignored in SETUP
      @(negedge _PCLK);
      lat++;
      for (int i = 0; i <= waits; i++) begin
        chk("access_penable", {31'd0, _PENABLE}, 32'd1);
        chk("access_sel", {30'd0, _PSEL2, _PSEL1}, exp_sel);
        chk("access_paddr", _PADDR, addr);
        chk("access_pwrite", {31'd0, _PWRITE}, {31'd0, wr});
        if (wr) chk("access_pwdata", _PWDATA, wd);
        chk("access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        _PREADY  = (i == waits);
        _PSLVERR = (i == waits) && serr;
        if (i != waits || wr) _PRDATA = $urandom;
        else if (serr)        _PRDATA = 'x;
        else                  _PRDATA = exp_rd;
        @(negedge _PCLK);
        lat++;
      end
      _PREADY  = 1'b0;
      _PSLVERR = 1'b0;
      _PRDATA  = $urandom;
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_latency", lat, 3 + waits);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, serr});
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("idle_sel", {30'd0, _PSEL2, _PSEL1}, 32'd0);
      chk("idle_penable", {31'd0, _PENABLE}, 32'd0);
    end
    chk("ready_in_rsp", {31'd0, req_ready}, 32'd0);
    @(negedge _PCLK);
    chk("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
    chk("ready_after_rsp", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic        wr;
    logic [31:0] a;
    _PRESET   = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    _PRDATA   = '0;
    _PREADY   = 1'b0;
    _PSLVERR  = 1'b0;

    // Reset state
    repeat (2) @(negedge _PCLK);
    chk("rst_sel", {30'd0, _PSEL2, _PSEL1}, 32'd0);
    chk("rst_ctrl", {30'd0, _PENABLE, _PWRITE}, 32'd0);
    chk("rst_paddr", _PADDR, 32'd0);
    chk("rst_pwdata", _PWDATA, 32'd0);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    _PRESET = 1'b0;
    @(negedge _PCLK);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    // Directed cases
    xfer(1'b1, 32'h04, 32'hDEADBEEF, 0, 1'b0);
    xfer(1'b0, 32'h04, 32'h0, 0, 1'b0);
    xfer(1'b1, 32'h24, 32'h12345678, 0, 1'b0);
    xfer(1'b0, 32'h24, 32'h0, 3, 1'b0);
    xfer(1'b0, 32'h08, 32'h0, 1, 1'b1);
    xfer(1'b1, 32'h40, 32'hCAFEF00D, 0, 1'b0);
    xfer(1'b0, 32'h40, 32'h0, 0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h40;
      else                           a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      xfer(wr, a, $urandom, int'($urandom_range(0, 4)), ($urandom_range(0, 5) == 0));
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Slave never ready: abort after TmoCycles ACCESS cycles
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0C;
    @(negedge _PCLK);
    req_valid = 1'b0;
    _PREADY   = 1'b0;
    @(negedge _PCLK);
    for (int i = 0; i < TmoCycles; i++) begin
      chk("tmo_penable", {31'd0, _PENABLE}, 32'd1);
      chk("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge _PCLK);
    end
    chk("tmo_rsp", {30'd0, rsp_valid, rsp_err}, 32'd3);
    chk("tmo_rdata", rsp_rdata, 32'd0);
    chk("tmo_penable_off", {31'd0, _PENABLE}, 32'd0);
    @(negedge _PCLK);
`endif

    // Reset pulsed mid-ACCESS: outputs drop without a clock edge, no response
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h04;
    @(negedge _PCLK);
    req_valid = 1'b0;
    @(negedge _PCLK);
    chk("abort_access", {29'd0, _PENABLE, _PSEL2, _PSEL1}, 32'd5);
    #2 _PRESET = 1'b1;
    #1;
    chk("abort_drop", {29'd0, _PENABLE, _PSEL2, _PSEL1}, 32'd0);
    @(negedge _PCLK);
    _PRESET = 1'b0;
    _PREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge _PCLK);
      chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
    end
    _PREADY = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB requester that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers toward up to two APB memory slaves. Sits directly upstream of the APB memory slaves: drives their select, enable, address, write-data and direction lines, and returns read data and error status to the command source. All sequencing follows the IDLE, SETUP and ACCESS phases used by the slaves.

## Interface
Parameters:
- ADDR_W, 32, address width of requests and _PADDR
- DATA_W, 32, data width
- SEL_BIT, 5, address bit that selects the slave: 0 selects slave 1, 1 selects slave 2
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without _PREADY; used only with the timeout feature

Ports:
- _PCLK  in  1  clock; all logic is rising-edge
- _PRESET  in  1  asynchronous, active-high reset
- req_valid  in  1  command present
- req_ready  out  1  command accepted when high together with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte/word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse; response fields valid
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  slave error, decode error, or timeout
- _PSEL1, _PSEL2  out  1  slave selects
- _PENABLE, _PWRITE  out  1  APB enable and direction
- _PADDR, _PWDATA  out  ADDR_W/DATA_W  APB address and write data
- _PRDATA  in  DATA_W  APB read data
- _PREADY, _PSLVERR  in  1  APB completion and error

## Operation
- FSM states: IDLE=0, SETUP=1, ACCESS=2.
- IDLE:
  - req_ready=1 only in IDLE.
  - On handshake, latch addr, wdata and write.
  - If req_addr[ADDR_W-1:SEL_BIT+1] != 0, this is a decode error: stay in IDLE, no select asserted, and rsp_valid=1 with rsp_err=1 next cycle.
  - Otherwise go to SETUP.
- SETUP:
  - Exactly one select high per _PADDR[SEL_BIT]; _PENABLE=0.
  - _PADDR, _PWRITE and _PWDATA are driven from the latch.
  - Next state is ACCESS unconditionally.
- ACCESS:
  - _PENABLE=1; the select and all address/data/direction outputs are held stable.
  - Stay while _PREADY=0.
  - When _PREADY=1, sample _PSLVERR and _PRDATA, then go to IDLE.
  - Next cycle: rsp_valid=1 and rsp_err=_PSLVERR.
  - rsp_rdata = _PRDATA only for a read with no error; otherwise 0. X/Z never propagates on errors.
- After completion, the select and _PENABLE drop to 0 in IDLE. There are no back-to-back transfers; at least one IDLE cycle separates transfers.
- rsp_valid has no backpressure; the consumer must accept the pulse.
- req_ready is 0 during the rsp_valid cycle, so the next handshake happens at the earliest one cycle after the response.

## Timing
- Reset (asynchronous, immediate): state=IDLE; _PSEL1, _PSEL2, _PENABLE, _PWRITE, rsp_valid and rsp_err are 0; _PADDR, _PWDATA and rsp_rdata are 0; req_ready=1 after reset deasserts.
- Zero-wait transfer, with the handshake at edge 0:
  - cycle 1: SETUP
  - cycle 2: ACCESS with _PREADY=1
  - cycle 3: rsp_valid
  - Total latency from handshake to response is 3 cycles. Each wait state adds 1 cycle.
- Decode error: rsp_valid one cycle after the handshake.
- Reset asserted mid-SETUP or mid-ACCESS: outputs drop immediately, and no response is issued for the aborted command.
- A _PREADY pulse during SETUP is ignored.

## Configuration
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with _PREADY=0.
  - When it reaches TIMEOUT_CYCLES, the transfer is aborted: go to IDLE, with rsp_valid=1, rsp_err=1 and rsp_rdata=0 the next cycle.
  - If _PREADY=1 arrives on the same cycle the limit is reached, _PREADY wins and the transfer completes normally.
- Undefined: there is no counter, ACCESS waits indefinitely, and TIMEOUT_CYCLES is unused.

## Structure
- Package apb_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS with values 0/1/2)
  - default widths
  - a response struct {rdata, err}
- Sub-module apb_timeout_counter (enable, clear, limit in; expired out) is instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Write 0xDEADBEEF to 0x04, then read 0x04 with zero waits: _PSEL1 in SETUP, rsp_valid 3 cycles after each handshake, read rsp_rdata=0xDEADBEEF, rsp_err=0.
- Read 0x24 with 3 wait states: _PSEL2=1, address/controls stable for 4 ACCESS cycles, rsp_valid at handshake+6.
- Slave returns _PSLVERR=1 on a read of 0x08: rsp_err=1, rsp_rdata=0.
- Request to address 0x40: no select ever asserted, rsp_valid and rsp_err one cycle after the handshake.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, _PREADY held low: abort after 16 ACCESS cycles, rsp_err=1, _PENABLE=0 next cycle.
- _PRESET pulsed during ACCESS: _PSEL1 and _PENABLE drop without waiting for a clock edge, no rsp_valid, req_ready=1 after release.
